// File: rtl/memreq_pkg.sv
// Shared types for the memory requester: FSM states, queued request entry, default depth.
package memreq_pkg;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRdWait,
      StRspHold
   } state_t;

   typedef struct packed {
      logic        write;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_entry_t;

endpackage

// File: rtl/memreq_fifo.sv
// In-order request queue; power-of-two depth so pointers wrap naturally.
module memreq_fifo
   import memreq_pkg::*;
#(
   parameter int unsigned Depth = FIFO_DEPTH_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  req_entry_t               push_data,
   input  logic                     pop,
   output req_entry_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

   req_entry_t          mem_q [Depth];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]       count_q;
   logic                do_push, do_pop;

   assign full    = (count_q == FullCount);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; entries are only read once pushed.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mem_requester.sv
// Queues load/store requests and issues them in order to a single-port RAM.
// Optional issue counters are enabled with the MEMREQ_STATS_EN macro.
module mem_requester
   import memreq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [15:0] mem_address,
   output logic [15:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [15:0] mem_read_data
`ifdef MEMREQ_STATS_EN
   ,
   output logic [15:0] stat_loads,
   output logic [15:0] stat_stores
`endif
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

   state_t      state_q, state_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic [15:0] mem_address_q, mem_address_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;

   req_entry_t      push_entry, head;
   logic            fifo_full, fifo_empty, push, pop;
   logic [CntW-1:0] fifo_count;
   logic            issue_store, issue_load, load_slot;

   assign req_ready  = !reset && (fifo_count != FullCount);
   assign push       = req_valid && req_ready && !fifo_full;
   assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};

   memreq_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A load may issue from idle, or on the edge that retires the held response.
   assign load_slot   = (state_q == StIdle) || ((state_q == StRspHold) && rsp_ready);
   assign issue_store = !fifo_empty && head.write;
   assign issue_load  = !fifo_empty && !head.write && load_slot;
   assign pop         = issue_store || issue_load;

   always_comb begin
      state_d       = state_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = 1'b0;

      if (pop) mem_address_d = head.addr;
      if (issue_store) begin
         mem_wdata_d = head.wdata;
         mem_we_d    = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (issue_load) state_d = StRdWait;
         end
         StRdWait: begin
            rsp_data_d  = mem_read_data;
            rsp_valid_d = 1'b1;
            state_d     = StRspHold;
         end
         StRspHold: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = issue_load ? StRdWait : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
      end
   end

   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign mem_address      = mem_address_q;
   assign mem_write_data   = mem_wdata_q;
   assign mem_write_enable = mem_we_q;

`ifdef MEMREQ_STATS_EN
   logic [15:0] stat_loads_q, stat_stores_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_loads_q  <= '0;
         stat_stores_q <= '0;
      end else begin
         if (issue_load)  stat_loads_q  <= stat_loads_q + 16'd1;
         if (issue_store) stat_stores_q <= stat_stores_q + 16'd1;
      end
   end

   assign stat_loads  = stat_loads_q;
   assign stat_stores = stat_stores_q;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed corner cases, a vector table and a
// randomized run against a shadow-memory model.
module tb_mem_requester;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic [15:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable;
`ifdef MEMREQ_STATS_EN
   logic [15:0] stat_loads, stat_stores;
`endif

   always #5 clock = ~clock;

   mem_requester #(
      .FIFO_DEPTH (4)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
`ifdef MEMREQ_STATS_EN
      ,
      .stat_loads       (stat_loads),
      .stat_stores      (stat_stores)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int we_count = 0;
   logic ram_init = 1'b0;
   logic [15:0] ram [0:255];
   logic [15:0] log_data [$];
   int          log_cyc [$];

   function automatic logic [15:0] init_val(input int a);
      if (a == 32) return 16'h1234;
      return 16'((a * 291) ^ 16'h5A5A);
   endfunction

   // RAM samples on the falling edge; read data is ready for the next rising edge.
   always @(negedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] = init_val(i);
      end else if (mem_write_enable) begin
         ram[mem_address[7:0]] = mem_write_data;
      end
      mem_read_data = ram[mem_address[7:0]];
   end

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset && rsp_valid && rsp_ready) begin
         log_data.push_back(rsp_data);
         log_cyc.push_back(cyc);
      end
      if (!reset && mem_write_enable) we_count++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      ram_init  = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      ram_init = 1'b0;
      reset    = 1'b0;
      tick();
   endtask

   task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 200) begin
         tick();
         n++;
      end
      check("push_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int base, input int n, input string name);
      int k = 0;
      while (log_data.size() < base + n && k < 300) begin
         tick();
         k++;
      end
      check(name, 32'(log_data.size() - base), 32'(n));
   endtask

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [7];
   logic [15:0] shadow [0:255];
   logic [15:0] exp_q [$];

   initial begin
      int base, wbase, nloads, j, stores;
      logic        hold_prev;
      logic [15:0] hold_data;

      tbl[0] = '{1'b1, 16'h0050, 16'h1111, 16'h0000};
      tbl[1] = '{1'b1, 16'h0051, 16'h2222, 16'h0000};
      tbl[2] = '{1'b0, 16'h0050, 16'h0000, 16'h1111};
      tbl[3] = '{1'b0, 16'h0051, 16'h0000, 16'h2222};
      tbl[4] = '{1'b1, 16'h0050, 16'h3333, 16'h0000};
      tbl[5] = '{1'b0, 16'h0050, 16'h0000, 16'h3333};
      tbl[6] = '{1'b0, 16'h0052, 16'h0000, init_val(32'h52)};

      // Reset values while asserted and after release
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_mem_addr", 32'(mem_address), 32'd0);
      check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
      check("rst_mem_we", 32'(mem_write_enable), 32'd0);
      do_reset();
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Store then load: one write pulse, data exactly two cycles after load acceptance
      wbase = we_count;
      base = log_data.size();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
      tick();
      req_write = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;
      check("st_we_pulse", 32'(mem_write_enable), 32'd0);
      tick();
      req_valid = 1'b0;
      check("st_we", 32'(mem_write_enable), 32'd1);
      check("st_addr", 32'(mem_address), 32'h0010);
      check("st_wdata", 32'(mem_write_data), 32'hBEEF);
      tick();
      check("ld_issue_we", 32'(mem_write_enable), 32'd0);
      check("ld_issue_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("ld_lat_valid", 32'(rsp_valid), 32'd1);
      check("ld_lat_data", 32'(rsp_data), 32'hBEEF);
      tick();
      tick();
      check("st_we_count", 32'(we_count - wbase), 32'd1);
      check("st_ld_rsp_count", 32'(log_data.size() - base), 32'd1);

      // Vector table: mixed stores/loads, responses in request order
      do_reset();
      rsp_ready = 1'b1;
      base = log_data.size();
      nloads = 0;
      foreach (tbl[i]) begin
         push(tbl[i].write, tbl[i].addr, tbl[i].wdata);
         if (!tbl[i].write) nloads++;
      end
      wait_rsp(base, nloads, "tbl_rsp_count");
      j = 0;
      foreach (tbl[i]) begin
         if (!tbl[i].write) begin
            if (base + j < log_data.size())
               check($sformatf("tbl_rsp_%0d", i), 32'(log_data[base+j]), 32'(tbl[i].exp));
            j++;
         end
      end

      // Full queue behind a held response: ready drops after 4, fifth waits, none lost
      do_reset();
      base = log_data.size();
      push(1'b0, 16'h0030, 16'h0);
      tick(); tick(); tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      for (int i = 1; i <= 4; i++) push(1'b0, 16'(16'h0030 + i), 16'h0);
      check("full_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0035;
      tick();
      check("full_still", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      j = 0;
      while (!req_ready && j < 50) begin
         tick();
         j++;
      end
      check("full_reopen", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      wait_rsp(base, 6, "full_rsp_count");
      for (int i = 0; i < 6; i++)
         if (base + i < log_data.size())
            check($sformatf("full_rsp_%0d", i), 32'(log_data[base+i]), 32'(init_val(48 + i)));

      // Held response stays stable while a later store issues
      do_reset();
      wbase = we_count;
      base = log_data.size();
      push(1'b0, 16'h0020, 16'h0);
      push(1'b1, 16'h0021, 16'hCAFE);
      tick();
      for (int i = 0; i < 6; i++) begin
         check($sformatf("hold_v_%0d", i), 32'(rsp_valid), 32'd1);
         check($sformatf("hold_d_%0d", i), 32'(rsp_data), 32'h1234);
         tick();
      end
      check("hold_store_we", 32'(we_count - wbase), 32'd1);
      check("hold_store_addr", 32'(mem_address), 32'h0021);
      check("hold_store_data", 32'(mem_write_data), 32'hCAFE);
      rsp_ready = 1'b1;
      tick();
      check("hold_release", 32'(rsp_valid), 32'd0);
      check("hold_rsp_count", 32'(log_data.size() - base), 32'd1);

      // Back-to-back loads: one response every 2 cycles, in order
      do_reset();
      rsp_ready = 1'b1;
      base = log_data.size();
      for (int i = 1; i <= 4; i++) push(1'b0, 16'(i), 16'h0);
      wait_rsp(base, 4, "b2b_rsp_count");
      if (log_data.size() >= base + 4) begin
         for (int i = 0; i < 4; i++)
            check($sformatf("b2b_data_%0d", i), 32'(log_data[base+i]), 32'(init_val(i + 1)));
         for (int i = 0; i < 3; i++)
            check($sformatf("b2b_gap_%0d", i), 32'(log_cyc[base+i+1] - log_cyc[base+i]), 32'd2);
      end

      // Reset during RD_WAIT discards the load
      do_reset();
      rsp_ready = 1'b1;
      push(1'b0, 16'h0040, 16'h0);
      tick();
      check("rdw_addr", 32'(mem_address), 32'h0040);
      check("rdw_valid", 32'(rsp_valid), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("rdw_rst_addr", 32'(mem_address), 32'd0);
      check("rdw_rst_ready", 32'(req_ready), 32'd0);
      check("rdw_rst_valid", 32'(rsp_valid), 32'd0);
      base = log_data.size();
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("rdw_no_rsp", 32'(log_data.size() - base), 32'd0);

`ifdef MEMREQ_STATS_EN
      do_reset();
      rsp_ready = 1'b1;
      base = log_data.size();
      push(1'b1, 16'h0060, 16'h0001);
      push(1'b0, 16'h0060, 16'h0);
      push(1'b1, 16'h0061, 16'h0002);
      push(1'b1, 16'h0062, 16'h0003);
      push(1'b0, 16'h0061, 16'h0);
      wait_rsp(base, 2, "stat_rsp_count");
      check("stat_stores", 32'(stat_stores), 32'd3);
      check("stat_loads", 32'(stat_loads), 32'd2);
`endif

      // Randomized traffic against a shadow memory updated in acceptance order
      do_reset();
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      exp_q.delete();
      base = log_data.size();
      wbase = we_count;
      stores = 0;
      hold_prev = 1'b0;
      hold_data = '0;
      for (int c = 0; c < 800; c++) begin
         if (hold_prev) begin
            check("rnd_hold_valid", 32'(rsp_valid), 32'd1);
            check("rnd_hold_data", 32'(rsp_data), 32'(hold_data));
         end
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = $urandom_range(0, 1) == 1;
         req_addr  = 16'($urandom_range(0, 15));
         req_wdata = 16'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (req_valid && req_ready) begin
            if (req_write) begin
               shadow[req_addr[7:0]] = req_wdata;
               stores++;
            end else begin
               exp_q.push_back(shadow[req_addr[7:0]]);
            end
         end
         hold_prev = rsp_valid && !rsp_ready;
         hold_data = rsp_data;
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_rsp(base, exp_q.size(), "rnd_rsp_count");
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < log_data.size())
            check($sformatf("rnd_rsp_%0d", i), 32'(log_data[base+i]), 32'(exp_q[i]));
      check("rnd_store_pulses", 32'(we_count - wbase), 32'(stores));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
